// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Contents: UART store address, transmitter FSM state type, default baud divider and
// FIFO depth.
package uart_pkg;

    localparam logic [31:0] UART_ADDR          = 32'h2000_0000;
    localparam int unsigned CLK_DIV_DEFAULT    = 868;  // 100 MHz / 115200
    localparam int unsigned FIFO_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_din  : write request and data; a push when full is accepted only with a pop
//   i_pop          : read request; ignored when empty
//   o_dout         : current head entry (register contents, valid when !o_empty)
//   o_full/o_empty : occupancy flags
//   o_count        : number of stored entries
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    // A simultaneous pop frees the slot being written, so a full FIFO can still accept.
    assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

    // Pointers wrap naturally because DEPTH is a power of two; r_count separates full/empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter (8N1, LSB first).
// Byte stores from the EX stage to UART_ADDR are queued in a FIFO and serialized on o_txd.
// Ports:
//   i_clk, i_rst_n : core clock, asynchronous active-low reset
//   i_mem_write    : store enable from EX stage
//   i_alu_result   : store address; exact 32-bit match against UART_ADDR
//   i_rs2_data     : store data; only bits [7:0] are sent regardless of store size
//   o_txd          : serial line, idle high, registered
//   o_tx_busy      : registered; high while bytes are queued or a frame is in flight
//   o_fifo_count   : bytes queued, excluding the frame in flight
//   o_drop_cnt     : saturating count of bytes discarded on a full FIFO
module uart_tx_mmio #(
    parameter  int unsigned CLK_DIV    = uart_pkg::CLK_DIV_DEFAULT,
    parameter  int unsigned FIFO_DEPTH = uart_pkg::FIFO_DEPTH_DEFAULT,
    parameter  logic [31:0] UART_ADDR  = uart_pkg::UART_ADDR,
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_mem_write,
    input  logic [31:0]      i_alu_result,
    input  logic [31:0]      i_rs2_data,
    output logic             o_txd,
    output logic             o_tx_busy,
    output logic [CNT_W-1:0] o_fifo_count,
    output logic [7:0]       o_drop_cnt
);

    import uart_pkg::*;

    localparam int unsigned       BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] RELOAD = BAUD_W'(CLK_DIV - 1);

    tx_state_t         r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit_idx;
    logic              r_txd;
    logic              r_tx_busy;
    logic [7:0]        r_drop_cnt;

    logic              w_push_req;
    logic              w_push_acc;
    logic              w_pop;
    logic              w_bit_done;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [7:0]        w_fifo_dout;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_active_next;

    assign w_push_req = i_mem_write && (i_alu_result == UART_ADDR);
    assign w_bit_done = (r_baud == '0);
    // The FIFO head is taken either from idle or straight out of a finished stop bit.
    assign w_pop      = !w_fifo_empty &&
                        ((r_state == IDLE) || ((r_state == STOP) && w_bit_done));
    assign w_push_acc = w_push_req && (!w_fifo_full || w_pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push_acc),
        .i_pop   (w_pop),
        .i_din   (i_rs2_data[7:0]),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // tx_busy reflects the post-edge state so it rises in the cycle right after a push.
    assign w_count_next  = w_fifo_count + CNT_W'(w_push_acc) - CNT_W'(w_pop);
    assign w_active_next = w_pop ||
                           ((r_state != IDLE) && !((r_state == STOP) && w_bit_done));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_push_req && !w_push_acc && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_txd     <= 1'b1;
            r_tx_busy <= 1'b0;
        end else begin
            r_tx_busy <= (w_count_next != '0) || w_active_next;
            // Count down to zero and hold; every state/bit entry below reloads it.
            if (!w_bit_done) begin
                r_baud <= r_baud - BAUD_W'(1);
            end
            unique case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_fifo_dout;
                        r_txd   <= 1'b0;
                        r_baud  <= RELOAD;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_bit_idx <= '0;
                        r_txd     <= r_shift[0];
                        r_baud    <= RELOAD;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_baud <= RELOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_bit_done) begin
                        r_baud <= RELOAD;
                        if (w_pop) begin
                            r_shift <= w_fifo_dout;
                            r_txd   <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_txd   <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_txd        = r_txd;
    assign o_tx_busy    = r_tx_busy;
    assign o_fifo_count = w_fifo_count;
    assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Synthesizable UART transmitter that consumes the data stage's byte stores to the UART address (0x2000_0000). It replaces the simulation-only character hook on the synthesis path.
- Store bytes are queued in a small FIFO.
- Bytes are serialized 8N1, LSB first, on txd.
- Sits beside the data memory and is driven by the same EX-stage address, store-enable and store-data signals the memory stage samples.

Parameters:
CLK_DIV, 868, clock cycles per bit (100 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 16, byte entries; power of two, >= 2
UART_ADDR, 32'h2000_0000, store address that targets the transmitter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_write  input  1  store enable from EX stage
alu_result  input  32  store address from EX stage
rs2_data  input  32  store data; bits [7:0] are the transmitted byte
txd  output  1  serial line; idle high
tx_busy  output  1  high while the FIFO is non-empty or a frame is in flight
fifo_count  output  $clog2(FIFO_DEPTH+1)  bytes queued, excluding the frame in flight
drop_cnt  output  8  saturating count of bytes dropped because the FIFO was full

Behaviour:
Interface decision: one clock; reset is asynchronous and active-low (ports clk, rst_n).

Reset:
- rst_n low immediately forces txd=1, tx_busy=0, fifo_count=0, drop_cnt=0, FSM=IDLE, baud counter=0, FIFO pointers=0.
- Asserting reset mid-frame aborts the frame; the partial character is not resent.

Push:
- Occurs on rising edge when mem_write && alu_result==UART_ADDR (exact 32-bit compare).
- Byte rs2_data[7:0] is written at that edge.
- The store size is ignored; SB, SH and SW to UART_ADDR all push the low byte.
- Accepted if fifo_count<FIFO_DEPTH, or if a pop happens on the same edge (count unchanged).
- Otherwise the byte is discarded and drop_cnt increments, saturating at 255.

FSM states: IDLE, START, DATA, STOP.
- Baud counter: reloads CLK_DIV-1 on each state/bit entry and decrements every cycle. "Bit done" means counter==0.
- IDLE: txd=1. On an edge with the FIFO non-empty: pop the head into an 8-bit shift register, enter START, txd<=0.
- START: txd=0 for CLK_DIV cycles; on bit done go to DATA with bit index=0, txd<=shift[0].
- DATA: each bit held CLK_DIV cycles, LSB first. On bit done: shift right, index+1. After index 7 completes go to STOP, txd<=1.
- STOP: txd=1 for CLK_DIV cycles. On bit done:
  - FIFO non-empty: pop and go directly to START. Back-to-back frames are exactly 10*CLK_DIV cycles apart.
  - FIFO empty: go to IDLE.

Timing and latency:
- A push at edge N into an idle, empty block makes txd fall at edge N+1.
- tx_busy is high from the cycle after edge N, i.e. it is registered from fifo_count!=0 || state!=IDLE.
- txd is a registered output with no combinational path from the inputs.

Other rules:
- mem_write to any other address is ignored.
- Non-store cycles have no effect.
- FIFO pointers wrap modulo FIFO_DEPTH. An extra wrap bit, or the count register, distinguishes full from empty.

Decomposition:
- Shared package uart_pkg:
  - UART_ADDR localparam
  - tx_state_t enum {IDLE, START, DATA, STOP}
  - default CLK_DIV and FIFO_DEPTH values
- Natural sub-module: sync_fifo.
  - Parameterized by WIDTH and DEPTH.
  - Ports: push, pop, din, dout (registered head), full, empty, count.
  - Same clk/rst_n. Reusable later for an RX path.
- Top level holds the address decode, drop counter, baud counter and FSM.

Test Plan:
All scenarios use CLK_DIV=4 and FIFO_DEPTH=4.
1. Reset, then single SB of 0x55 to 0x2000_0000 at edge N -> txd low at N+1 for 4 cycles, then 1,0,1,0,1,0,1,0 each held 4 cycles, then high for 4 cycles. tx_busy returns to 0 after 40 cycles total.
2. Three consecutive stores of 'A','B','C' -> three frames with no idle gap (stop of A followed immediately by start of B). fifo_count peaks at 2. Received bytes are 0x41,0x42,0x43.
3. Six stores in six consecutive cycles while idle -> first pops at once, four queue, sixth dropped. drop_cnt=1. Five bytes transmitted in order.
4. Store to 0x2000_0004 and to 0x1000_0000 -> no push, txd stays 1, fifo_count=0.
5. Assert rst_n low mid-DATA of frame 0xA3 with 2 bytes queued -> txd=1 asynchronously, fifo_count=0, no further frames after release.
6. SW of 0xDEADBEEF to UART_ADDR -> single frame carrying 0xEF.
